// File: rtl/gray_code_conv_pipe.sv
// Pipelined bidirectional Gray code converter with valid/ready handshake.
// Each transaction carries its own mode bit. Stage 0 registers the converted
// value; later stages are plain register slices with bubble-collapsing
// backpressure. Latency is STAGES cycles when out_ready stays high.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers in_data/in_mode
//   in_ready   stage 0 can load this cycle (combinational from out_ready/flags)
//   in_mode    0: binary->Gray, 1: Gray->binary
//   in_data    value to convert
//   out_valid  last stage holds a result
//   out_ready  consumer takes the result this cycle
//   out_mode   mode the result was converted with
//   out_data   converted value
module gray_code_conv_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            mode_q, mode_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            load_c;
  logic [WIDTH-1:0]             conv_c;

  // Conversion: MSB passes through in both directions.
  always_comb begin
    conv_c = '0;
    conv_c[WIDTH-1] = in_data[WIDTH-1];
    if (in_mode) begin
      // Gray->binary is a running XOR from the MSB down.
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
        conv_c[i] = conv_c[i+1] ^ in_data[i];
      end
    end else begin
      for (int i = 0; i < int'(WIDTH) - 1; i++) begin
        conv_c[i] = in_data[i+1] ^ in_data[i];
      end
    end
  end

  // A stage may load when empty or when the stage after it loads.
  always_comb begin
    logic chain;
    chain  = out_ready;
    load_c = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      chain     = ~vld_q[k] | chain;
      load_c[k] = chain;
    end
  end

  // Next-state: shift where allowed; payload only moves with a valid entry.
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    data_d = data_q;
    if (load_c[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = conv_c;
        mode_d[0] = in_mode;
      end
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (load_c[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          data_d[k] = data_q[k-1];
          mode_d[k] = mode_q[k-1];
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = load_c[0];
  assign out_valid = vld_q[LAST];
  assign out_mode  = mode_q[LAST];
  assign out_data  = data_q[LAST];

endmodule
